// File: rtl/nes_cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, 6502 addressing modes, opcode constants
// and the opcode -> instruction length/illegal lookup used by the fetch stage.
`ifndef BYTE
`define BYTE 8
`endif

package nes_cpu_pkg;

    localparam int MEM_ADDR_SIZE = 16;

    typedef enum logic [1:0] {
        S_RESET,
        S_REQ,
        S_RESP,
        S_HOLD
    } fetch_state_e;

    typedef enum logic [3:0] {
        AM_IMP,
        AM_ACC,
        AM_IMM,
        AM_ZPG,
        AM_ZPX,
        AM_ZPY,
        AM_IZX,
        AM_IZY,
        AM_REL,
        AM_ABS,
        AM_ABX,
        AM_ABY,
        AM_IND,
        AM_ILL
    } addr_mode_e;

    localparam logic [`BYTE-1:0] ORA_IMM   = 8'h09;
    localparam logic [`BYTE-1:0] ORA_ZPG   = 8'h05;
    localparam logic [`BYTE-1:0] ORA_ZPG_X = 8'h15;
    localparam logic [`BYTE-1:0] ORA_ABS   = 8'h0D;
    localparam logic [`BYTE-1:0] LDA_IMM   = 8'hA9;
    localparam logic [`BYTE-1:0] JMP_ABS   = 8'h4C;
    localparam logic [`BYTE-1:0] JMP_IND   = 8'h6C;
    localparam logic [`BYTE-1:0] JSR_ABS   = 8'h20;
    localparam logic [`BYTE-1:0] BRK       = 8'h00;
    localparam logic [`BYTE-1:0] NOP       = 8'hEA;

    typedef struct packed {
        logic [1:0] len;
        logic       illegal;
    } instr_len_t;

    // Official NMOS 6502 opcode set; anything not listed is treated as illegal.
    function automatic addr_mode_e addr_mode(input logic [`BYTE-1:0] op);
        addr_mode_e m;
        m = AM_ILL;
        case (op)
            8'h00, 8'h08, 8'h18, 8'h28, 8'h38, 8'h40, 8'h48, 8'h58,
            8'h60, 8'h68, 8'h78, 8'h88, 8'h8A, 8'h98, 8'h9A, 8'hA8,
            8'hAA, 8'hB8, 8'hBA, 8'hC8, 8'hCA, 8'hD8, 8'hE8, 8'hEA,
            8'hF8:                                          m = AM_IMP;
            8'h0A, 8'h2A, 8'h4A, 8'h6A:                     m = AM_ACC;
            8'h09, 8'h29, 8'h49, 8'h69, 8'hA9, 8'hC9, 8'hE9,
            8'hA0, 8'hA2, 8'hC0, 8'hE0:                     m = AM_IMM;
            8'h05, 8'h25, 8'h45, 8'h65, 8'h85, 8'hA5, 8'hC5, 8'hE5,
            8'h06, 8'h26, 8'h46, 8'h66, 8'h86, 8'hA6, 8'hC6, 8'hE6,
            8'h24, 8'h84, 8'hA4, 8'hC4, 8'hE4:              m = AM_ZPG;
            8'h15, 8'h35, 8'h55, 8'h75, 8'h95, 8'hB5, 8'hD5, 8'hF5,
            8'h16, 8'h36, 8'h56, 8'h76, 8'hD6, 8'hF6,
            8'h94, 8'hB4:                                   m = AM_ZPX;
            8'h96, 8'hB6:                                   m = AM_ZPY;
            8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1, 8'hE1:
                                                            m = AM_IZX;
            8'h11, 8'h31, 8'h51, 8'h71, 8'h91, 8'hB1, 8'hD1, 8'hF1:
                                                            m = AM_IZY;
            8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0:
                                                            m = AM_REL;
            8'h0D, 8'h2D, 8'h4D, 8'h6D, 8'h8D, 8'hAD, 8'hCD, 8'hED,
            8'h0E, 8'h2E, 8'h4E, 8'h6E, 8'h8E, 8'hAE, 8'hCE, 8'hEE,
            8'h2C, 8'h8C, 8'hAC, 8'hCC, 8'hEC, 8'h4C, 8'h20: m = AM_ABS;
            8'h6C:                                          m = AM_IND;
            8'h1D, 8'h3D, 8'h5D, 8'h7D, 8'h9D, 8'hBD, 8'hDD, 8'hFD,
            8'h1E, 8'h3E, 8'h5E, 8'h7E, 8'hDE, 8'hFE,
            8'hBC:                                          m = AM_ABX;
            8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hD9, 8'hF9,
            8'hBE:                                          m = AM_ABY;
            default:                                        m = AM_ILL;
        endcase
        return m;
    endfunction

    // Illegal opcodes are consumed as single bytes so fetch keeps moving.
    function automatic instr_len_t instr_len(input logic [`BYTE-1:0] op);
        instr_len_t r;
        r.len     = 2'd1;
        r.illegal = 1'b0;
        case (addr_mode(op))
            AM_IMP, AM_ACC:                               r.len = 2'd1;
            AM_IMM, AM_ZPG, AM_ZPX, AM_ZPY,
            AM_IZX, AM_IZY, AM_REL:                       r.len = 2'd2;
            AM_ABS, AM_ABX, AM_ABY, AM_IND:               r.len = 2'd3;
            default: begin
                r.len     = 2'd1;
                r.illegal = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fetch_t_len_dec.sv
// Combinational opcode length decoder for the fetch stage.
module fetch_len_dec_t
    import nes_cpu_pkg::*;
(
    input  logic [`BYTE-1:0] opcode_i,
    output logic [1:0]       len_o,
    output logic             illegal_o
);

    instr_len_t dec;

    assign dec       = instr_len(opcode_i);
    assign len_o     = dec.len;
    assign illegal_o = dec.illegal;

endmodule

// File: rtl/fetch_t.sv
// Instruction fetch stage: reads 3-byte words from mem_t and hands aligned 1..3 byte
// instructions to decode over valid/ready. Optional counters under FETCH_PERF_EN.
module fetch_t
    import nes_cpu_pkg::*;
#(
    parameter logic [MEM_ADDR_SIZE-1:0] RESET_PC = '0
)
(
    input  logic                     clk_i,
    input  logic                     rstn_i,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
    input  logic [3*`BYTE-1:0]       mem_data_i,
    input  logic                     redirect_i,
    input  logic [MEM_ADDR_SIZE-1:0] redirect_pc_i,
    output logic                     instr_valid_o,
    input  logic                     instr_ready_i,
    output logic [3*`BYTE-1:0]       instr_o,
    output logic [MEM_ADDR_SIZE-1:0] instr_pc_o,
    output logic [1:0]               instr_len_o,
    output logic                     instr_illegal_o,
`ifdef FETCH_PERF_EN
    output logic [31:0]              fetch_cnt_o,
    output logic [31:0]              stall_cnt_o,
`endif
    output fetch_state_e             dbg_state_o
);

    // Handshake: a bundle transfers on any edge where instr_valid_o & instr_ready_i;
    // while valid & !ready the bundle is frozen, and valid only falls after a
    // transfer or a redirect.

    fetch_state_e             state_q, state_d;
    logic [MEM_ADDR_SIZE-1:0] pc_q, pc_d;
    logic [MEM_ADDR_SIZE-1:0] instr_pc_q, instr_pc_d;
    logic [3*`BYTE-1:0]       instr_q, instr_d;
    logic [3*`BYTE-1:0]       masked;
    logic [1:0]               len_q, len_d;
    logic                     illegal_q, illegal_d;
    logic                     valid_q, valid_d;
    logic [1:0]               dec_len;
    logic                     dec_illegal;

    fetch_len_dec_t u_len_dec (
        .opcode_i  (mem_data_i[`BYTE-1:0]),
        .len_o     (dec_len),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        masked = mem_data_i;
        case (dec_len)
            2'd3:    masked = mem_data_i;
            2'd2:    masked = {{`BYTE{1'b0}}, mem_data_i[2*`BYTE-1:0]};
            default: masked = {{(2*`BYTE){1'b0}}, mem_data_i[`BYTE-1:0]};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        instr_d    = instr_q;
        len_d      = len_q;
        illegal_d  = illegal_q;
        valid_d    = valid_q;

        if (redirect_i) begin
            // Also drops a read in flight; a coincident transfer is simply consumed.
            pc_d    = redirect_pc_i;
            valid_d = 1'b0;
            state_d = S_REQ;
        end else begin
            case (state_q)
                S_RESET: state_d = S_REQ;
                S_REQ:   state_d = S_RESP;
                S_RESP: begin
                    instr_d    = masked;
                    instr_pc_d = pc_q;
                    len_d      = dec_len;
                    illegal_d  = dec_illegal;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + {{(MEM_ADDR_SIZE-2){1'b0}}, dec_len};
                    state_d    = S_HOLD;
                end
                S_HOLD: begin
                    // mem_t has been sampling the advanced pc_q, so data is ready next cycle.
                    if (instr_ready_i) begin
                        valid_d = 1'b0;
                        state_d = S_RESP;
                    end
                end
                default: state_d = S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_RESET;
            pc_q       <= RESET_PC;
            instr_pc_q <= '0;
            instr_q    <= '0;
            len_q      <= '0;
            illegal_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            instr_q    <= instr_d;
            len_q      <= len_d;
            illegal_q  <= illegal_d;
            valid_q    <= valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;
    logic        xfer;

    assign xfer = valid_q & instr_ready_i;

    // Both counters saturate rather than wrap and ignore redirects.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (xfer && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((state_q == S_HOLD) && !instr_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

    assign mem_addr_o      = pc_q;
    assign instr_valid_o   = valid_q;
    assign instr_o         = instr_q;
    assign instr_pc_o      = instr_pc_q;
    assign instr_len_o     = len_q;
    assign instr_illegal_o = illegal_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_fetch_t.sv
// Bench for fetch_t: mem_t model, randomized ready/redirect driver, and a scoreboard
// fed by an ISA-level length model. Also elaborates a second copy with RESET_PC near the top.
module tb_fetch_t;
    import nes_cpu_pkg::*;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] WRAP_PC  = 16'hFFFE;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rstn_i;
    always #5 clk_i = ~clk_i;

    // ---------------- DUT signals ----------------
    logic [15:0]  mem_addr_o, redirect_pc_i, instr_pc_o;
    logic [23:0]  mem_data_i, instr_o;
    logic         redirect_i, instr_valid_o, instr_ready_i, instr_illegal_o;
    logic [1:0]   instr_len_o;
    fetch_state_e dbg_state_o;

    logic [15:0]  w_addr, w_pc;
    logic [23:0]  w_data, w_instr;
    logic         w_valid, w_ill;
    logic [1:0]   w_len;
    fetch_state_e w_state;
`ifdef FETCH_PERF_EN
    logic [31:0]  fetch_cnt_o, stall_cnt_o, w_fetch_cnt, w_stall_cnt;
`endif

    logic [7:0] mem [0:65535];

    fetch_t #(.RESET_PC(RESET_PC)) u_dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .mem_addr_o      (mem_addr_o),
        .mem_data_i      (mem_data_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_len_o     (instr_len_o),
        .instr_illegal_o (instr_illegal_o),
`ifdef FETCH_PERF_EN
        .fetch_cnt_o     (fetch_cnt_o),
        .stall_cnt_o     (stall_cnt_o),
`endif
        .dbg_state_o     (dbg_state_o)
    );

    fetch_t #(.RESET_PC(WRAP_PC)) u_dut_wrap (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .mem_addr_o      (w_addr),
        .mem_data_i      (w_data),
        .redirect_i      (1'b0),
        .redirect_pc_i   (16'h0000),
        .instr_valid_o   (w_valid),
        .instr_ready_i   (1'b1),
        .instr_o         (w_instr),
        .instr_pc_o      (w_pc),
        .instr_len_o     (w_len),
        .instr_illegal_o (w_ill),
`ifdef FETCH_PERF_EN
        .fetch_cnt_o     (w_fetch_cnt),
        .stall_cnt_o     (w_stall_cnt),
`endif
        .dbg_state_o     (w_state)
    );

    // mem_t: one-cycle registered read of three consecutive bytes, address wraps.
    always @(posedge clk_i) begin
        mem_data_i <= {mem[mem_addr_o + 16'd2], mem[mem_addr_o + 16'd1], mem[mem_addr_o]};
        w_data     <= {mem[w_addr + 16'd2], mem[w_addr + 16'd1], mem[w_addr]};
    end

    // ---------------- bookkeeping ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    int bundles      = 0;
    int xfer_cnt     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Length by official 6502 opcode lists; everything else is illegal, 1 byte.
    function automatic logic [2:0] ref_len(input logic [7:0] op);
        if (op inside {8'h0D, 8'h0E, 8'h19, 8'h1D, 8'h1E, 8'h20, 8'h2C, 8'h2D, 8'h2E, 8'h39,
                       8'h3D, 8'h3E, 8'h4C, 8'h4D, 8'h4E, 8'h59, 8'h5D, 8'h5E, 8'h6C, 8'h6D,
                       8'h6E, 8'h79, 8'h7D, 8'h7E, 8'h8C, 8'h8D, 8'h8E, 8'h99, 8'h9D, 8'hAC,
                       8'hAD, 8'hAE, 8'hB9, 8'hBC, 8'hBD, 8'hBE, 8'hCC, 8'hCD, 8'hCE, 8'hD9,
                       8'hDD, 8'hDE, 8'hEC, 8'hED, 8'hEE, 8'hF9, 8'hFD, 8'hFE})
            return {1'b0, 2'd3};
        if (op inside {8'h01, 8'h05, 8'h06, 8'h09, 8'h10, 8'h11, 8'h15, 8'h16, 8'h21, 8'h24,
                       8'h25, 8'h26, 8'h29, 8'h30, 8'h31, 8'h35, 8'h36, 8'h41, 8'h45, 8'h46,
                       8'h49, 8'h50, 8'h51, 8'h55, 8'h56, 8'h61, 8'h65, 8'h66, 8'h69, 8'h70,
                       8'h71, 8'h75, 8'h76, 8'h81, 8'h84, 8'h85, 8'h86, 8'h90, 8'h91, 8'h94,
                       8'h95, 8'h96, 8'hA0, 8'hA1, 8'hA2, 8'hA4, 8'hA5, 8'hA6, 8'hA9, 8'hB0,
                       8'hB1, 8'hB4, 8'hB5, 8'hB6, 8'hC0, 8'hC1, 8'hC4, 8'hC5, 8'hC6, 8'hC9,
                       8'hD0, 8'hD1, 8'hD5, 8'hD6, 8'hE0, 8'hE1, 8'hE4, 8'hE5, 8'hE6, 8'hE9,
                       8'hF0, 8'hF1, 8'hF5, 8'hF6})
            return {1'b0, 2'd2};
        if (op inside {8'h00, 8'h08, 8'h0A, 8'h18, 8'h28, 8'h2A, 8'h38, 8'h40, 8'h48, 8'h4A,
                       8'h58, 8'h60, 8'h68, 8'h6A, 8'h78, 8'h88, 8'h8A, 8'h98, 8'h9A, 8'hA8,
                       8'hAA, 8'hB8, 8'hBA, 8'hC8, 8'hCA, 8'hD8, 8'hE8, 8'hEA, 8'hF8})
            return {1'b0, 2'd1};
        return {1'b1, 2'd1};
    endfunction

    // Packed bundle: {illegal, len[1:0], pc[15:0], instr[23:0]}
    function automatic logic [42:0] ref_bundle(input logic [15:0] pc);
        logic [7:0]  op, b1, b2;
        logic [2:0]  li;
        logic [23:0] ins;
        op = mem[pc];
        b1 = mem[pc + 16'd1];
        b2 = mem[pc + 16'd2];
        li = ref_len(op);
        if (li[1:0] == 2'd3)      ins = {b2, b1, op};
        else if (li[1:0] == 2'd2) ins = {8'h00, b1, op};
        else                      ins = {16'h0000, op};
        return {li[2], li[1:0], pc, ins};
    endfunction

    // ---------------- scoreboard ----------------
    logic [42:0] exp_q[$];
    logic [15:0] model_pc;
    logic [42:0] held, cur, exp_b;
    logic        prev_valid, prev_xfer, prev_redir;

    function automatic void push_next();
        logic [42:0] b;
        b = ref_bundle(model_pc);
        exp_q.push_back(b);
        model_pc = model_pc + {14'b0, b[41:40]};
    endfunction

    always @(negedge clk_i) begin
        if (!rstn_i) begin
            check("rst_valid", 64'(instr_valid_o), 64'd0);
            check("rst_bundle", 64'({instr_illegal_o, instr_len_o, instr_pc_o, instr_o}), 64'd0);
            exp_q.delete();
            model_pc   = RESET_PC;
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
            prev_redir = 1'b0;
            xfer_cnt   = 0;
        end else begin
            cur = {instr_illegal_o, instr_len_o, instr_pc_o, instr_o};
            if (instr_valid_o && (!prev_valid || prev_xfer)) begin
                if (exp_q.size() == 0) push_next();
                exp_b = exp_q.pop_front();
                check("bundle", 64'(cur), 64'(exp_b));
                bundles++;
            end else if (prev_valid && !prev_xfer) begin
                if (prev_redir) check("redirect_drop", 64'(instr_valid_o), 64'd0);
                else            check("hold_stable", 64'({instr_valid_o, cur}), 64'({1'b1, held}));
            end
            if (instr_valid_o && instr_ready_i) xfer_cnt++;
            if (redirect_i) begin
                exp_q.delete();
                model_pc = redirect_pc_i;
                push_next();
                push_next();
            end
            prev_valid = instr_valid_o;
            prev_xfer  = instr_valid_o && instr_ready_i;
            prev_redir = redirect_i;
            held       = cur;
        end
    end

    // ---------------- wrap instance checker ----------------
    initial begin : wrap_chk
        logic [15:0] exp_pc [2];
        int n;
        exp_pc[0] = WRAP_PC;
        exp_pc[1] = 16'h0000;
        @(posedge rstn_i);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            @(negedge clk_i);
            while (!w_valid && n < 10) begin
                @(negedge clk_i);
                n++;
            end
            check("wrap_valid", 64'(w_valid), 64'd1);
            check("wrap_pc", 64'(w_pc), 64'(exp_pc[k]));
            check("wrap_bundle", 64'({w_ill, w_len, w_pc, w_instr}), 64'(ref_bundle(exp_pc[k])));
            @(negedge clk_i);
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        while (!instr_valid_o && n < max_cyc) begin
            step();
            n++;
        end
        check("wait_valid", 64'(instr_valid_o), 64'd1);
    endtask

    initial begin : main
`ifdef FETCH_PERF_EN
        logic [31:0] stall0;
`endif
        rstn_i        = 1'b0;
        instr_ready_i = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'h09; mem[1] = 8'h55;
        mem[2] = 8'h0D; mem[3] = 8'h34; mem[4] = 8'h12; mem[5] = 8'hEA;
        mem[6] = 8'h02;
        mem[WRAP_PC] = 8'hA9;

        repeat (2) step();
        check("rst_mem_addr", 64'(mem_addr_o), 64'(RESET_PC));
        check("rst_state", 64'(dbg_state_o), 64'(S_RESET));
        rstn_i = 1'b1;

        for (int k = 1; k <= 3; k++) begin
            step();
            check("latency_valid", 64'(instr_valid_o), 64'(k == 3));
        end
        check("first_instr", 64'(instr_o), 64'h005509);
        check("first_pc", 64'(instr_pc_o), 64'h0000);
        check("first_len", 64'(instr_len_o), 64'd2);
        check("next_pc", 64'(mem_addr_o), 64'h0002);

        repeat (20) step();

        // stall in S_HOLD for five cycles
        instr_ready_i = 1'b0;
        wait_valid(10);
`ifdef FETCH_PERF_EN
        stall0 = stall_cnt_o;
`endif
        repeat (5) step();
        check("stall_valid", 64'(instr_valid_o), 64'd1);
`ifdef FETCH_PERF_EN
        check("stall_cnt", 64'(stall_cnt_o - stall0), 64'd5);
`endif
        instr_ready_i = 1'b1;
        repeat (4) step();

        // redirect while holding an unaccepted bundle
        instr_ready_i = 1'b0;
        wait_valid(10);
        redirect_i    = 1'b1;
        redirect_pc_i = 16'h0100;
        step();
        redirect_i = 1'b0;
        check("redirect_valid_drop", 64'(instr_valid_o), 64'd0);
        instr_ready_i = 1'b1;
        wait_valid(10);
        check("redirect_pc", 64'(instr_pc_o), 64'h0100);

        // randomized ready and redirects, some near the top of memory
        repeat (400) begin
            instr_ready_i = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) begin
                redirect_i = 1'b1;
                case ($urandom_range(0, 3))
                    0:       redirect_pc_i = 16'hFFFE;
                    1:       redirect_pc_i = 16'hFFFF;
                    default: redirect_pc_i = 16'($urandom_range(0, 65535));
                endcase
            end else begin
                redirect_i = 1'b0;
            end
            step();
        end
        redirect_i    = 1'b0;
        instr_ready_i = 1'b1;

        // asynchronous reset while a read is in flight
        wait_valid(10);
        step();
        check("pre_reset_state", 64'(dbg_state_o), 64'(S_RESP));
        #2 rstn_i = 1'b0;
        #1;
        check("async_rst_valid", 64'(instr_valid_o), 64'd0);
        check("async_rst_bundle", 64'({instr_illegal_o, instr_len_o, instr_pc_o, instr_o}), 64'd0);
        check("async_rst_addr", 64'(mem_addr_o), 64'(RESET_PC));
        check("async_rst_state", 64'(dbg_state_o), 64'(S_RESET));
        step();
        rstn_i = 1'b1;
        wait_valid(10);
        check("restart_pc", 64'(instr_pc_o), 64'(RESET_PC));
        check("restart_instr", 64'(instr_o), 64'h005509);
        repeat (20) step();

        instr_ready_i = 1'b0;
        repeat (3) step();
`ifdef FETCH_PERF_EN
        check("fetch_cnt", 64'(fetch_cnt_o), 64'(xfer_cnt));
`endif
        check("progress", 64'(bundles >= 50), 64'd1);
        check("scoreboard_used", 64'(bundles > 0 && xfer_cnt > 0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
